head_move_seq: RTL

- Sequences multi-cell head moves for the BeeF tape head.
- Accepts a run-length move command (direction plus count) over a valid/ready handshake.
- Steps the head pointer one cell per clock until the count is exhausted, then pulses done.
- Sits between instruction decode (coalesced MVR/MVL runs) and the tape address path. Provides head_ptr to the tape memory and supports load and abort from the core controller.

---
 rtl/head_move_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/head_move_seq.sv
// -----------------------------------------------------------------------------
// head_move_seq
//
// Run-length head-move sequencer for the BeeF tape head. A move command
// (direction plus cell count) is accepted over a valid/ready handshake. The
// sequencer then steps the head pointer one cell per clock until the count is
// used up, and pulses done in the cycle where the final pointer is visible.
// The core controller can reload the head pointer or abort a move in flight.
//
// Optional build macro:
//   HEAD_BOUND_CHECK_EN - when defined, a step that would cross the tape end is
//                         suppressed. The move then ends with an aborted pulse
//                         and with wrapped set as a fault flag. When undefined,
//                         the pointer wraps modulo 2^HEAD_W and the move always
//                         completes.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   cmd_valid     in   move command present
//   cmd_ready     out  command can be accepted (high only in IDLE)
//   cmd_dir       in   0 = right (+1, MVR), 1 = left (-1, MVL)
//   cmd_count     in   number of cells to move (CNT_W bits)
//   head_load     in   load head pointer from head_load_val (any state)
//   head_load_val in   value for head_load (HEAD_W bits)
//   abort         in   terminate the current move (ignored in IDLE)
//   head_ptr      out  registered head pointer / tape address
//   busy          out  high while a move is stepping
//   done          out  one-cycle pulse: move completed, head_ptr is final
//   aborted       out  one-cycle pulse: move ended by abort, load or bound fault
//   wrapped       out  sticky: current or last move crossed the tape end
// -----------------------------------------------------------------------------
module head_move_seq #(
   parameter int HEAD_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [CNT_W-1:0]  cmd_count,
   input  logic              head_load,
   input  logic [HEAD_W-1:0] head_load_val,
   input  logic              abort,
   output logic [HEAD_W-1:0] head_ptr,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic              wrapped
);

   typedef enum logic {
      IDLE = 1'b0,
      MOVE = 1'b1
   } state_t;

   localparam logic [HEAD_W-1:0] PTR_MAX  = '1;
   localparam logic [HEAD_W-1:0] PTR_MIN  = '0;
   localparam logic [HEAD_W-1:0] PTR_ONE  = HEAD_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ZERO = '0;

   // Registered state and its next-state values.
   state_t            state_q,     state_d;
   logic [HEAD_W-1:0] ptr_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic              dir_q,       dir_d;
   logic              done_d;
   logic              aborted_d;
   logic              wrapped_d;

   // Helpers derived from the current state.
   logic              accept;
   logic              at_end;
   logic              bound_fault;
   logic [HEAD_W-1:0] step_ptr;

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q == MOVE);

   // A command is never taken on an edge where load or abort is asserted,
   // even though cmd_ready itself only reflects the state.
   assign accept = cmd_valid && cmd_ready && !head_load && !abort;

   // at_end: the next step in the latched direction would cross the tape end.
   assign at_end   = dir_q ? (head_ptr == PTR_MIN) : (head_ptr == PTR_MAX);
   assign step_ptr = dir_q ? (head_ptr - PTR_ONE) : (head_ptr + PTR_ONE);

`ifdef HEAD_BOUND_CHECK_EN
   assign bound_fault = at_end;
`else
   assign bound_fault = 1'b0;
`endif

   // NOTE: every output of this block gets a default before any branch, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      ptr_d       = head_ptr;
      remaining_d = remaining_q;
      dir_d       = dir_q;
      done_d      = 1'b0;
      aborted_d   = 1'b0;
      wrapped_d   = wrapped;

      if (head_load) begin
         // Load wins over abort, accept and step. Interrupting a move counts
         // as an abort; a load in IDLE is silent.
         ptr_d       = head_load_val;
         state_d     = IDLE;
         remaining_d = CNT_ZERO;
         aborted_d   = (state_q == MOVE);
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  dir_d     = cmd_dir;
                  wrapped_d = 1'b0;
                  if (cmd_count == CNT_ZERO) begin
                     // Zero-length move: nothing to step, report done at once.
                     done_d = 1'b1;
                  end else begin
                     remaining_d = cmd_count;
                     state_d     = MOVE;
                  end
               end
            end

            MOVE: begin
               if (abort) begin
                  // Pointer holds: no step on the abort edge.
                  state_d     = IDLE;
                  remaining_d = CNT_ZERO;
                  aborted_d   = 1'b1;
               end else if (bound_fault) begin
                  // Bounded build only: refuse to cross the tape end and flag it.
                  state_d     = IDLE;
                  remaining_d = CNT_ZERO;
                  aborted_d   = 1'b1;
                  wrapped_d   = 1'b1;
               end else begin
                  ptr_d       = step_ptr;
                  remaining_d = remaining_q - CNT_ONE;
                  if (at_end) begin
                     wrapped_d = 1'b1;
                  end
                  // Last step: done lines up with the final pointer value.
                  if (remaining_q == CNT_ONE) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end
            end

            default: begin
               state_d     = IDLE;
               remaining_d = CNT_ZERO;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         head_ptr    <= '0;
         remaining_q <= '0;
         dir_q       <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
         wrapped     <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_ptr    <= ptr_d;
         remaining_q <= remaining_d;
         dir_q       <= dir_d;
         done        <= done_d;
         aborted     <= aborted_d;
         wrapped     <= wrapped_d;
      end
   end

endmodule
